// File: rtl/caravel_ccff_chain_if.sv
// rtl/caravel_ccff_chain_if.sv - serial head/tail and parallel config bundle for the CCFF chain
// Optional CCFF_PARITY_EN adds cfg_parity to the bundle.
interface caravel_ccff_chain_if #(
  parameter int BITSTREAM_SIZE = 29696,
  parameter int COUNT_W        = 16
);
  logic                      ccff_head;
  logic                      ccff_tail;
  logic [BITSTREAM_SIZE-1:0] cfg_q;
  logic [COUNT_W-1:0]        cfg_count;
  logic                      config_done;
`ifdef CCFF_PARITY_EN
  logic                      cfg_parity;

  modport master (
    output ccff_head,
    input  ccff_tail,
    input  cfg_q,
    input  cfg_count,
    input  config_done,
    input  cfg_parity
  );

  modport slave (
    input  ccff_head,
    output ccff_tail,
    output cfg_q,
    output cfg_count,
    output config_done,
    output cfg_parity
  );
`else
  modport master (
    output ccff_head,
    input  ccff_tail,
    input  cfg_q,
    input  cfg_count,
    input  config_done
  );

  modport slave (
    input  ccff_head,
    output ccff_tail,
    output cfg_q,
    output cfg_count,
    output config_done
  );
`endif
endinterface

// File: rtl/caravel_ccff_chain.sv
// rtl/caravel_ccff_chain.sv - configuration flip-flop shift chain with saturating bit counter
// Optional CCFF_PARITY_EN: running XOR of captured head bits, frozen at config_done.
module caravel_ccff_chain #(
  parameter int BITSTREAM_SIZE = 29696,
  parameter int COUNT_W        = 16
) (
  input  logic               prog_clk,
  input  logic               prog_reset,
  caravel_ccff_chain_if.slave ccff
);

  localparam logic [COUNT_W-1:0] FULL    = COUNT_W'(BITSTREAM_SIZE);
  localparam logic [COUNT_W-1:0] FULL_M1 = COUNT_W'(BITSTREAM_SIZE - 1);

  if (BITSTREAM_SIZE < 1 || (64'd1 << COUNT_W) <= 64'(BITSTREAM_SIZE)) begin : g_bad_params
    $error("caravel_ccff_chain: COUNT_W too narrow for BITSTREAM_SIZE");
  end

  logic [BITSTREAM_SIZE-1:0] chain_q;
  logic [BITSTREAM_SIZE-1:0] chain_d;
  logic [COUNT_W-1:0]        count_q;
  logic                      done_q;

  // Head enters bit 0; a single-bit chain has nothing to shift from.
  if (BITSTREAM_SIZE == 1) begin : g_one
    assign chain_d = ccff.ccff_head;
  end else begin : g_many
    assign chain_d = {chain_q[BITSTREAM_SIZE-2:0], ccff.ccff_head};
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  // done rises on the same edge the counter reaches FULL, then holds until reset.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      if (count_q != FULL) begin
        count_q <= count_q + 1'b1;
      end
      if (count_q == FULL_M1) begin
        done_q <= 1'b1;
      end
    end
  end

  assign ccff.cfg_q       = chain_q;
  assign ccff.ccff_tail   = chain_q[BITSTREAM_SIZE-1];
  assign ccff.cfg_count   = count_q;
  assign ccff.config_done = done_q;

`ifdef CCFF_PARITY_EN
  logic parity_q;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      parity_q <= 1'b0;
    end else if (!done_q) begin
      parity_q <= parity_q ^ ccff.ccff_head;
    end
  end

  assign ccff.cfg_parity = parity_q;
`endif

endmodule

// File: tb/tb_caravel_ccff_chain.sv
// tb/tb_caravel_ccff_chain.sv - scoreboard bench: full-size, all-zero and 8-bit chain instances
// Parity checks compile in only when CCFF_PARITY_EN is defined.
module tb_caravel_ccff_chain;

  localparam int BIG   = 29696;
  localparam int SMALL = 8;

  localparam int S_BIG_TAIL    = 0;
  localparam int S_BIG_DONE    = 1;
  localparam int S_BIG_COUNT   = 2;
  localparam int S_BIG_ANY     = 3;
  localparam int S_BIG_LOW16   = 4;
  localparam int S_ZERO_TAIL   = 5;
  localparam int S_ZERO_ANY    = 6;
  localparam int S_SMALL_TAIL  = 7;
  localparam int S_SMALL_DONE  = 8;
  localparam int S_SMALL_COUNT = 9;
  localparam int S_SMALL_Q     = 10;
  localparam int S_SMALL_PAR   = 11;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } sb_item_t;

  logic     prog_clk;
  logic     prog_reset;
  event     sample_ev;
  sb_item_t sb_q[$];
  int       vectors;
  int       miscompares;

  caravel_ccff_chain_if #(.BITSTREAM_SIZE(BIG),   .COUNT_W(16)) big_if();
  caravel_ccff_chain_if #(.BITSTREAM_SIZE(BIG),   .COUNT_W(16)) zero_if();
  caravel_ccff_chain_if #(.BITSTREAM_SIZE(SMALL), .COUNT_W(4))  small_if();

  caravel_ccff_chain #(.BITSTREAM_SIZE(BIG), .COUNT_W(16)) u_big (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .ccff       (big_if.slave)
  );

  caravel_ccff_chain #(.BITSTREAM_SIZE(BIG), .COUNT_W(16)) u_zero (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .ccff       (zero_if.slave)
  );

  caravel_ccff_chain #(.BITSTREAM_SIZE(SMALL), .COUNT_W(4)) u_small (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .ccff       (small_if.slave)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  function automatic void expect_v(input int sel, input logic [31:0] exp, input string name);
    sb_item_t it;
    it.sel  = sel;
    it.exp  = exp;
    it.name = name;
    sb_q.push_back(it);
  endfunction

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_BIG_TAIL:    return {31'b0, big_if.ccff_tail};
      S_BIG_DONE:    return {31'b0, big_if.config_done};
      S_BIG_COUNT:   return {16'b0, big_if.cfg_count};
      S_BIG_ANY:     return {31'b0, |big_if.cfg_q};
      S_BIG_LOW16:   return {16'b0, big_if.cfg_q[15:0]};
      S_ZERO_TAIL:   return {31'b0, zero_if.ccff_tail};
      S_ZERO_ANY:    return {31'b0, |zero_if.cfg_q};
      S_SMALL_TAIL:  return {31'b0, small_if.ccff_tail};
      S_SMALL_DONE:  return {31'b0, small_if.config_done};
      S_SMALL_COUNT: return {28'b0, small_if.cfg_count};
      S_SMALL_Q:     return {24'b0, small_if.cfg_q};
`ifdef CCFF_PARITY_EN
      S_SMALL_PAR:   return {31'b0, small_if.cfg_parity};
`endif
      default:       return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: drains every expectation queued for the edge (or async event) just past.
  initial begin
    sb_item_t    it;
    logic [31:0] act;
    vectors     = 0;
    miscompares = 0;
    forever begin
      @(posedge prog_clk or sample_ev);
      #1;
      while (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = actual(it.sel);
        vectors++;
        if (act !== it.exp) begin
          miscompares++;
          $display("FAIL %s: got %0h expected %0h at %0t", it.name, act, it.exp, $time);
        end
      end
    end
  end

  task automatic expect_all_reset();
    expect_v(S_BIG_TAIL,    32'd0, "rst_big_tail");
    expect_v(S_BIG_DONE,    32'd0, "rst_big_done");
    expect_v(S_BIG_COUNT,   32'd0, "rst_big_count");
    expect_v(S_BIG_ANY,     32'd0, "rst_big_cfg_q");
    expect_v(S_SMALL_TAIL,  32'd0, "rst_small_tail");
    expect_v(S_SMALL_DONE,  32'd0, "rst_small_done");
    expect_v(S_SMALL_COUNT, 32'd0, "rst_small_count");
    expect_v(S_SMALL_Q,     32'd0, "rst_small_cfg_q");
`ifdef CCFF_PARITY_EN
    expect_v(S_SMALL_PAR,   32'd0, "rst_small_parity");
`endif
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b1101;  // pat[0] is the first bit shifted: 1,0,1,1
    prog_reset         = 1'b1;
    big_if.ccff_head   = 1'b0;
    zero_if.ccff_head  = 1'b0;
    small_if.ccff_head = 1'b0;
    #1;
    expect_all_reset();
    -> sample_ev;
    #1999;

    // Phase A: long run on the full-size chains, single 1 on edge 2 (big) / edge 1 (small).
    @(negedge prog_clk);
    prog_reset = 1'b0;
    for (int e = 1; e <= 30000; e++) begin
      big_if.ccff_head   = (e == 2);
      small_if.ccff_head = (e == 1);
      zero_if.ccff_head  = 1'b0;
      expect_v(S_BIG_TAIL,  {31'b0, e == BIG + 1}, "big_tail");
      expect_v(S_BIG_DONE,  {31'b0, e >= BIG},     "big_done");
      expect_v(S_BIG_COUNT, (e < BIG) ? e : BIG,   "big_count");
      if (e <= 29700) begin
        expect_v(S_ZERO_TAIL, 32'd0, "zero_tail");
        expect_v(S_ZERO_ANY,  32'd0, "zero_cfg_q");
      end
      if (e <= 20) begin
        expect_v(S_SMALL_TAIL,  {31'b0, e == SMALL},          "small_tail");
        expect_v(S_SMALL_DONE,  {31'b0, e >= SMALL},          "small_done");
        expect_v(S_SMALL_COUNT, (e < SMALL) ? e : SMALL,      "small_count");
        expect_v(S_SMALL_Q,     (e <= SMALL) ? (32'd1 << (e - 1)) : 32'd0, "small_cfg_q");
      end
      @(negedge prog_clk);
    end

    // Phase B: reset a saturated chain, shift 1,0,1,1 + ten zeros, then reset mid-cycle.
    prog_reset = 1'b1;
    #1;
    expect_all_reset();
    -> sample_ev;
    @(negedge prog_clk);
    prog_reset = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      big_if.ccff_head   = (e <= 4) ? pat[e-1] : 1'b0;
      small_if.ccff_head = (e <= 3);
      expect_v(S_BIG_COUNT, e, "b_big_count");
      if (e == 8) begin
        expect_v(S_SMALL_Q,    32'h0000_00e0, "b_small_cfg_q");
        expect_v(S_SMALL_TAIL, 32'd1,         "b_small_tail");
      end
      if (e == 14) begin
        expect_v(S_BIG_LOW16,   32'h0000_2c00, "b_big_cfg_q_13_10");
        expect_v(S_BIG_DONE,    32'd0,         "b_big_done");
        expect_v(S_SMALL_DONE,  32'd1,         "b_small_done");
        expect_v(S_SMALL_COUNT, 32'd8,         "b_small_count");
`ifdef CCFF_PARITY_EN
        expect_v(S_SMALL_PAR,   32'd1,         "b_small_parity");
`endif
      end
      @(negedge prog_clk);
    end
    #1;
    prog_reset = 1'b1;
    expect_all_reset();
    -> sample_ev;
    repeat (3) @(negedge prog_clk);

    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/caravel_ccff_chain.md
CARAVEL_CCFF_CHAIN -- requirements
Module: caravel_ccff_chain

Interface
REQ-001 SHALL have parameter BITSTREAM_SIZE, default 29696, number of configuration flip-flops in the chain.
REQ-002 SHALL have parameter COUNT_W, default 16, width of the shift counter; COUNT_W SHALL be large enough to hold BITSTREAM_SIZE.
REQ-003 SHALL have port prog_clk, input, 1, programming clock; every register is rising-edge triggered.
REQ-004 SHALL have port prog_reset, input, 1, programming reset; asynchronous and active-high.
REQ-005 SHALL have port ccff_head, input, 1, serial configuration data into the chain head.
REQ-006 SHALL have port ccff_tail, output, 1, serial data out of the chain tail.
REQ-007 SHALL have port cfg_q, output, BITSTREAM_SIZE, parallel configuration bits for the fabric; bit 0 is nearest the head.
REQ-008 SHALL have port cfg_count, output, COUNT_W, number of bits shifted since reset, saturating.
REQ-009 SHALL have port config_done, output, 1, high once BITSTREAM_SIZE bits have been shifted.

Function
REQ-010 On each prog_clk rise with prog_reset low: cfg_q[0] <= ccff_head and cfg_q[i] <= cfg_q[i-1] for i = 1..BITSTREAM_SIZE-1.
REQ-011 ccff_tail SHALL equal cfg_q[BITSTREAM_SIZE-1] combinationally, with no extra register stage.
REQ-012 A bit captured at edge k SHALL appear on ccff_tail after edge k+BITSTREAM_SIZE-1 and leave it after edge k+BITSTREAM_SIZE.
REQ-013 cfg_count SHALL increment by 1 per edge and saturate at BITSTREAM_SIZE with no wrap-around.
REQ-014 config_done SHALL be asserted, registered, when cfg_count == BITSTREAM_SIZE.
REQ-015 Shifting SHALL continue after config_done; config_done SHALL stay high until reset.
REQ-016 The chain has no enable and no handshake; every edge outside reset is a shift.
REQ-017 X on ccff_head SHALL propagate down the chain unmodified; there is no filtering.

Reset
REQ-018 While prog_reset is high: cfg_q = all 0, ccff_tail = 0, cfg_count = 0, config_done = 0, independent of prog_clk.
REQ-019 Reset asserted mid-shift SHALL clear all state immediately.
REQ-020 After reset release, the first prog_clk rise SHALL capture into cfg_q[0] and set cfg_count to 1.
REQ-021 A prog_clk rise coincident with reset release is ignored.

Configuration
REQ-022 Macro CCFF_PARITY_EN defined: SHALL add output cfg_parity, 1 bit, registered.
REQ-023 cfg_parity SHALL be the XOR of all ccff_head values captured since reset.
REQ-024 cfg_parity SHALL be 0 in reset.
REQ-025 cfg_parity SHALL freeze once config_done is high.
REQ-026 Macro CCFF_PARITY_EN undefined: the cfg_parity port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Reset held 2000 ns, then ccff_head = 1 for only the 2nd edge and 0 otherwise -> ccff_tail = 0 through edge 29696; ccff_tail = 1 after edge 29697; ccff_tail = 0 after edge 29698 and onward.
REQ-028 ccff_head held 0 for 29700 edges -> ccff_tail = 0 and cfg_q = 0 throughout.
REQ-029 Shift 29696 edges -> config_done = 0 after edge 29695; config_done = 1 and cfg_count = 29696 after edge 29696; cfg_count still 29696 after edge 30000.
REQ-030 Shift pattern 1,0,1,1 then zeros for 10 edges -> cfg_q[13:10] = 4'b1011 (cfg_q[13] = first bit); then reset asynchronously mid-cycle -> all outputs 0 before the next edge.
REQ-031 CCFF_PARITY_EN defined, head bits 1,1,1 then zeros -> cfg_parity = 1; undefined -> build has no cfg_parity port.
REQ-032 BITSTREAM_SIZE = 8 with a single 1 captured at edge 1 -> ccff_tail = 1 after edge 8 only; config_done = 1 from edge 8.
